// File: rtl/control_sequencer.sv
// control_sequencer: Moore micro-sequencer (fetch T0-T2, execute T3-T7, HALT, FAULT) with registered control outputs.
// Build option MEM_WAIT_EN: memory states stretch until mem_rdy, faulting after WAIT_LIMIT idle cycles.
module control_sequencer #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortOut,
  output logic        PCin,
  output logic        incPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic [4:0]  opcode,
  output logic        run,
  output logic        fault,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_e;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UN, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } cls_e;

  typedef struct packed {
    logic       pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out, c_out, inport_out;
    logic       pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic       gra, grb, grc, r_in, r_out, ba_out;
    logic       read, write;
    logic [4:0] opcode;
    logic       run, fault;
  } ctrl_t;

  localparam logic [4:0] OpAdd = 5'b00011;

`ifdef MEM_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  localparam int              CntW    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_LIMIT - 1);

  function automatic cls_e classify(input logic [4:0] op);
    cls_e c;
    c = C_ILL;
    if (op == 5'd0)                      c = C_LD;
    else if (op == 5'd1)                 c = C_LDI;
    else if (op == 5'd2)                 c = C_ST;
    else if (op >= 5'd3 && op <= 5'd11)  c = C_ALU;
    else if (op >= 5'd12 && op <= 5'd14) c = C_IMM;
    else if (op == 5'd15 || op == 5'd16) c = C_MULDIV;
    else if (op == 5'd17 || op == 5'd18) c = C_UN;
    else if (op == 5'd24)                c = C_MFHI;
    else if (op == 5'd25)                c = C_MFLO;
    else if (op == 5'd26)                c = C_NOP;
    else if (op == 5'd27)                c = C_HALT;
    return c;
  endfunction

  // Control word presented while in state s for an instruction of class c.
  function automatic ctrl_t decode(input state_e s, input cls_e c, input logic [4:0] op);
    ctrl_t o;
    o        = '0;
    o.opcode = OpAdd;
    o.run    = 1'b1;
    case (s)
      S_T0: begin o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1; end
      S_T1: begin o.zlow_out = 1'b1; o.pc_in = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1; end
      S_T2: begin o.mdr_out = 1'b1; o.ir_in = 1'b1; end
      S_T3: case (c)
        C_ALU, C_MULDIV:   begin o.grb = 1'b1; o.r_out = 1'b1; o.y_in = 1'b1; end
        C_UN:              begin o.grb = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; o.opcode = op; end
        C_IMM, C_LDI, C_LD, C_ST: begin o.grb = 1'b1; o.ba_out = 1'b1; o.y_in = 1'b1; end
        C_MFHI:            begin o.hi_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        C_MFLO:            begin o.lo_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        default: ;
      endcase
      S_T4: case (c)
        C_ALU, C_MULDIV:   begin o.grc = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; o.opcode = op; end
        C_UN:              begin o.zlow_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        C_IMM:             begin o.c_out = 1'b1; o.z_in = 1'b1; o.opcode = op; end
        C_LDI, C_LD, C_ST: begin o.c_out = 1'b1; o.z_in = 1'b1; end
        default: ;
      endcase
      S_T5: case (c)
        C_ALU, C_IMM, C_LDI: begin o.zlow_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        C_MULDIV:            begin o.zlow_out = 1'b1; o.lo_in = 1'b1; end
        C_LD, C_ST:          begin o.zlow_out = 1'b1; o.mar_in = 1'b1; end
        default: ;
      endcase
      S_T6: case (c)
        C_MULDIV: begin o.zhigh_out = 1'b1; o.hi_in = 1'b1; end
        C_LD:     begin o.read = 1'b1; o.mdr_in = 1'b1; end
        C_ST:     begin o.gra = 1'b1; o.r_out = 1'b1; o.mdr_in = 1'b1; end
        default: ;
      endcase
      S_T7: case (c)
        C_LD:    begin o.mdr_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        C_ST:    o.write = 1'b1;
        default: ;
      endcase
      S_HALT:  o.run = 1'b0;
      S_FAULT: begin o.run = 1'b0; o.fault = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  state_e          state_q, state_d;
  cls_e            cls_q, cls_d;
  logic [4:0]      op_q, op_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            primed_q;
  logic            mem_state;
  ctrl_t           ctrl_q, ctrl_d;
  logic            unused_ir;

  assign unused_ir = ^ir[26:0];

  // Memory handshake: a memory state keeps its strobe (valid) asserted until a
  // cycle with mem_rdy=1 (ready); that cycle is the last one of the state.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    op_d       = op_q;
    wait_cnt_d = '0;
    mem_state  = (state_q == S_T1) ||
                 (state_q == S_T6 && cls_q == C_LD) ||
                 (state_q == S_T7 && cls_q == C_ST);
    if (!primed_q) begin
      state_d = S_T0;
    end else begin
      case (state_q)
        S_T0: state_d = S_T1;
        S_T1: state_d = S_T2;
        S_T2: state_d = S_T3;
        S_T3: case (cls_q)
          C_ILL:                 state_d = S_FAULT;
          C_HALT:                state_d = S_HALT;
          C_MFHI, C_MFLO, C_NOP: state_d = S_T0;
          default:               state_d = S_T4;
        endcase
        S_T4:    state_d = (cls_q == C_UN) ? S_T0 : S_T5;
        S_T5:    state_d = (cls_q inside {C_LD, C_ST, C_MULDIV}) ? S_T6 : S_T0;
        S_T6:    state_d = (cls_q == C_MULDIV) ? S_T0 : S_T7;
        S_T7:    state_d = S_T0;
        default: state_d = state_q;
      endcase
      if (WaitEn && mem_state && !mem_rdy) begin
        if (wait_cnt_q == CntLast) begin
          state_d = S_FAULT;
        end else begin
          state_d    = state_q;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    end
    if (state_d == S_T3) begin
      cls_d = classify(ir[31:27]);
      op_d  = ir[31:27];
    end
    ctrl_d = decode(state_d, cls_d, op_d);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_T0;
      cls_q         <= C_NOP;
      op_q          <= OpAdd;
      wait_cnt_q    <= '0;
      primed_q      <= 1'b0;
      ctrl_q        <= '0;
      ctrl_q.opcode <= OpAdd;
      ctrl_q.run    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      primed_q   <= 1'b1;
      ctrl_q     <= ctrl_d;
    end
  end

  assign PCout     = ctrl_q.pc_out;
  assign MDRout    = ctrl_q.mdr_out;
  assign ZLowOut   = ctrl_q.zlow_out;
  assign ZHighOut  = ctrl_q.zhigh_out;
  assign HIout     = ctrl_q.hi_out;
  assign LOout     = ctrl_q.lo_out;
  assign Cout      = ctrl_q.c_out;
  assign InPortOut = ctrl_q.inport_out;
  assign PCin      = ctrl_q.pc_in;
  assign incPC     = ctrl_q.inc_pc;
  assign MARin     = ctrl_q.mar_in;
  assign MDRin     = ctrl_q.mdr_in;
  assign IRin      = ctrl_q.ir_in;
  assign Yin       = ctrl_q.y_in;
  assign Zin       = ctrl_q.z_in;
  assign HIin      = ctrl_q.hi_in;
  assign LOin      = ctrl_q.lo_in;
  assign Gra       = ctrl_q.gra;
  assign Grb       = ctrl_q.grb;
  assign Grc       = ctrl_q.grc;
  assign Rin       = ctrl_q.r_in;
  assign Rout      = ctrl_q.r_out;
  assign BAout     = ctrl_q.ba_out;
  assign read      = ctrl_q.read;
  assign write     = ctrl_q.write;
  assign opcode    = ctrl_q.opcode;
  assign run       = ctrl_q.run;
  assign fault     = ctrl_q.fault;
  assign dbg_state = state_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 8: maximum memory-wait cycles before fault (used only with MEM_WAIT_EN).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port clr, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port ir, input, 32: IR contents; opcode is ir[31:27].
REQ-005 SHALL have port mem_rdy, input, 1: memory completion strobe.
REQ-006 SHALL have outputs PCout, MDRout, ZLowOut, ZHighOut, HIout, LOout, Cout, InPortOut, each 1 bit: bus source selects.
REQ-007 SHALL have outputs PCin, incPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, each 1 bit: register loads.
REQ-008 SHALL have outputs Gra, Grb, Grc, Rin, Rout, BAout, each 1 bit: register-select controls.
REQ-009 SHALL have outputs read and write, each 1 bit: memory strobes; read also drives MDR Read.
REQ-010 SHALL have output opcode, 5 bits: ALU operation.
REQ-011 SHALL have output run, 1 bit: high unless halted or faulted.
REQ-012 SHALL have output fault, 1 bit: high for illegal opcode or wait timeout.

Function
REQ-013 SHALL be a Moore FSM with states T0..T7, HALT and FAULT; all outputs are registered or decoded from state only, never from ir combinationally within the same cycle.
REQ-014 SHALL execute fetch as follows:
- T0: PCout, MARin, incPC, Zin.
- T1: ZLowOut, PCin, read, MDRin.
- T2: MDRout, IRin.
- Then T3.
REQ-015 SHALL decode opcodes:
- 00000 ld, 00001 ldi, 00010 st.
- 00011–01011: R-type ALU (add, sub, and, or, shr, shra, shl, ror, rol).
- 01100 addi, 01101 andi, 01110 ori.
- 01111 mul, 10000 div, 10001 neg, 10010 not.
- 11000 mfhi, 11001 mflo, 11010 nop, 11011 halt.
- All other codes are illegal.
REQ-016 SHALL sequence R-type: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin with opcode=ir[31:27]; T5 ZLowOut,Gra,Rin; then T0.
REQ-017 SHALL sequence mul/div like R-type through T4, then T5 ZLowOut,LOin; T6 ZHighOut,HIin; then T0.
REQ-018 SHALL sequence neg/not: T3 Grb,Rout,Zin with opcode; T4 ZLowOut,Gra,Rin; then T0.
REQ-019 SHALL sequence addi/andi/ori/ldi: T3 Grb,BAout,Yin; T4 Cout,Zin, with opcode=ir[31:27] for immediates and add (00011) for ldi; T5 ZLowOut,Gra,Rin; then T0.
REQ-020 SHALL sequence ld: T3/T4 as ldi; T5 ZLowOut,MARin; T6 read,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-021 SHALL sequence st: T3–T5 as ld; T6 Gra,Rout,MDRin (read low); T7 write; then T0.
REQ-022 SHALL sequence mfhi/mflo: T3 HIout/LOout with Gra,Rin; then T0.
REQ-023 SHALL treat nop as T3 idle, then T0.
REQ-024 SHALL enter HALT on halt; HALT asserts no strobes, run=0, and is left only by clr.
REQ-025 SHALL enter FAULT on an illegal opcode at T3; FAULT asserts fault=1, run=0, no strobes, and is left only by clr.
REQ-026 SHALL output opcode=00011 (add) in every state where the sequence above does not specify opcode.
REQ-027 SHALL keep all unlisted outputs at 0 in every state.
REQ-028 SHALL ensure read and write are never high in the same cycle.

Reset
REQ-029 SHALL, on clk edge with clr=1, enter T0 with all strobes 0, opcode=00011, run=1, fault=0, and wait counter 0; clr overrides every state, including mid-instruction, HALT and FAULT.
REQ-030 SHALL, on the first edge after clr falls, output T0 fetch strobes.

Configuration
REQ-031 SHALL, with MEM_WAIT_EN defined, hold read-states (T1, ld T6) and the write-state (st T7) with strobes asserted until a cycle with mem_rdy=1; that cycle is the last of the state.
REQ-032 SHALL, with MEM_WAIT_EN defined, count wait cycles and enter FAULT when the count reaches WAIT_LIMIT without mem_rdy; mem_rdy in the same cycle as the limit wins.
REQ-033 SHALL, without MEM_WAIT_EN, give each memory state exactly one cycle, ignore mem_rdy, and never take the timeout fault path.

Verification
REQ-034 SHALL cover: clr 1 cycle, ir=add R1,R2,R3 (0x18918000) -> T0..T5 with T4 opcode=00011, T5 Gra,Rin; 6 cycles to next T0.
REQ-035 SHALL cover: ir=mul (opcode 01111) -> T5 LOin, T6 HIin; 7 cycles total; opcode=01111 at T4.
REQ-036 SHALL cover: ir=st (opcode 00010) -> T6 MDRin with read=0, T7 write=1; read and write never coincident.
REQ-037 SHALL cover: ir opcode 11111 -> FAULT at cycle 4, fault=1, run=0, strobes 0 until clr; clr then gives T0.
REQ-038 SHALL cover: MEM_WAIT_EN, mem_rdy low 3 cycles in T1 -> T1 held 4 cycles; mem_rdy low 8 cycles -> FAULT.
REQ-039 SHALL cover: clr asserted during ld T6 -> next cycle T0, all strobes 0, read=0.
